// File: rtl/mc_control_if.sv
// -----------------------------------------------------------------------------
// mc_control_if
//   Bundles the signals between the multicycle sequencer (mc_control) and the
//   rest of the core: memory handshake, alufpu branch flags, alufpu controls,
//   register-file / PC / memory strobes and debug status.
//
//   master : the sequencer (drives controls and strobes, reads flags/memory)
//   slave  : datapath + memory side (the mirror image of master)
//
//   instr          32  instruction word, valid while mem_ready is high in FETCH
//   mem_ready       1  memory access completes this cycle
//   gp_branch       1  alufpu integer branch condition
//   fp_branch       1  alufpu FP branch condition
//   ALUctrl         4  ALU operation select
//   FPUctrl         1  FPU operation: 0 add, 1 multiply
//   alu_src_imm     1  1 selects sign-extended imm16 as busB
//   ir_write        1  latch instruction register
//   pc_write        1  PC <= next PC
//   pc_sel_target   1  with pc_write: 1 target, 0 PC+4
//   mem_read        1  memory read request
//   mem_write       1  memory write request
//   reg_write       1  GPR write strobe
//   freg_write      1  FPR write strobe
//   wb_sel          2  writeback source: 0 ALU, 1 FPU, 2 memory, 3 PC+4
//   trap            1  sticky trap flag
//   state           3  current sequencer state (debug)
// -----------------------------------------------------------------------------
interface mc_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        gp_branch;
  logic        fp_branch;
  logic [3:0]  ALUctrl;
  logic        FPUctrl;
  logic        alu_src_imm;
  logic        ir_write;
  logic        pc_write;
  logic        pc_sel_target;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        freg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state;

  modport master (
    input  instr, mem_ready, gp_branch, fp_branch,
    output ALUctrl, FPUctrl, alu_src_imm, ir_write, pc_write, pc_sel_target,
           mem_read, mem_write, reg_write, freg_write, wb_sel, trap, state
  );

  modport slave (
    output instr, mem_ready, gp_branch, fp_branch,
    input  ALUctrl, FPUctrl, alu_src_imm, ir_write, pc_write, pc_sel_target,
           mem_read, mem_write, reg_write, freg_write, wb_sel, trap, state
  );
endinterface

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
//   Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer sitting upstream of the
//   alufpu execute block. Decodes op/func, holds alufpu controls stable from
//   EXEC through WB, resolves branches from the alufpu flags and steps the
//   register-file, PC and memory strobes. Waits on mem_ready in FETCH and MEM
//   and traps (sticky, exit only by reset) on an illegal opcode or when
//   MEM_TIMEOUT consecutive wait cycles elapse (MEM_TIMEOUT = 0 disables).
//
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    mc_control_if.master (see interface file for the signal list)
// -----------------------------------------------------------------------------
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mc_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_FP, C_ADDI, C_LW, C_SW, C_BEQZ, C_BNEZ,
    C_BFPT, C_BFPF, C_J, C_JAL, C_ILL
  } iclass_e;

  // One spare count of headroom so MEM_TIMEOUT itself always fits.
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_e           state_q, state_d;
  iclass_e          iclass_q, iclass_d;
  logic [5:0]       op_q, op_d;
  logic [3:0]       func_q, func_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             fpu_ctrl_q, fpu_ctrl_d;
  logic             alu_src_imm_q, alu_src_imm_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ir_write, pc_write, pc_sel_target, mem_read, mem_write;
  logic reg_write, freg_write;

  iclass_e    dec_class;
  logic [3:0] dec_alu;
  logic       dec_fpu;
  logic       dec_imm;
  logic [1:0] dec_wb;
  logic       timeout_hit;

  // The full IR lives in the datapath; only op and func[3:0] steer control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[25:4];

  // Reaching CNT_LAST with mem_ready still low is the last allowed wait cycle;
  // a ready on that same cycle takes priority in the FSM below.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // Instruction classification from the latched op/func fields.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec_class = C_ILL;
    dec_alu   = 4'd0;
    dec_fpu   = 1'b0;
    dec_imm   = 1'b0;
    dec_wb    = 2'd0;
    case (op_q)
      6'h00: begin dec_class = C_R;    dec_alu = func_q;                  end
      6'h01: begin dec_class = C_FP;   dec_fpu = func_q[0]; dec_wb = 2'd1; end
      6'h08: begin dec_class = C_ADDI; dec_imm = 1'b1;                    end
      6'h23: begin dec_class = C_LW;   dec_imm = 1'b1;     dec_wb = 2'd2; end
      6'h2B: begin dec_class = C_SW;   dec_imm = 1'b1;                    end
      6'h04: begin dec_class = C_BEQZ; dec_alu = 4'd12;                   end
      6'h05: begin dec_class = C_BNEZ; dec_alu = 4'd13;                   end
      6'h06: dec_class = C_BFPT;
      6'h07: dec_class = C_BFPF;
      6'h02: dec_class = C_J;
      6'h03: begin dec_class = C_JAL;  dec_wb = 2'd3;                     end
      default: dec_class = C_ILL;
    endcase
  end

  // Next-state, registered-control next values and per-state strobes.
  always_comb begin
    state_d       = state_q;
    iclass_d      = iclass_q;
    op_d          = op_q;
    func_d        = func_q;
    alu_ctrl_d    = alu_ctrl_q;
    fpu_ctrl_d    = fpu_ctrl_q;
    alu_src_imm_d = alu_src_imm_q;
    wb_sel_d      = wb_sel_q;
    trap_d        = trap_q;
    cnt_d         = cnt_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel_target = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    freg_write    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          op_d     = bus.instr[31:26];
          func_d   = bus.instr[3:0];
          cnt_d    = '0;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          trap_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        iclass_d = dec_class;
        if (dec_class == C_ILL) begin
          trap_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          // Latched here so alufpu sees stable controls from EXEC entry to WB exit.
          alu_ctrl_d    = dec_alu;
          fpu_ctrl_d    = dec_fpu;
          alu_src_imm_d = dec_imm;
          wb_sel_d      = dec_wb;
          state_d       = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_WB;
        case (iclass_q)
          C_BEQZ, C_BNEZ: begin pc_write = bus.gp_branch;  state_d = S_FETCH; end
          C_BFPT:         begin pc_write = bus.fp_branch;  state_d = S_FETCH; end
          C_BFPF:         begin pc_write = ~bus.fp_branch; state_d = S_FETCH; end
          C_J:            begin pc_write = 1'b1;           state_d = S_FETCH; end
          C_JAL:          pc_write = 1'b1;
          C_LW, C_SW:     state_d  = S_MEM;
          default:        state_d  = S_WB;
        endcase
        pc_sel_target = pc_write;
      end

      S_MEM: begin
        mem_read  = (iclass_q == C_LW);
        mem_write = (iclass_q != C_LW);
        if (bus.mem_ready) begin
          cnt_d   = '0;
          state_d = (iclass_q == C_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          trap_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        freg_write = (iclass_q == C_FP);
        reg_write  = (iclass_q != C_FP);
        state_d    = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: begin
        trap_d  = 1'b1;
        state_d = S_TRAP;
      end
    endcase

    // state_q already sits at FETCH during reset; without this gate FETCH's
    // mem_read would be visible while reset is still held.
    if (reset) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_sel_target = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      freg_write    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_FETCH;
      iclass_q      <= C_R;
      op_q          <= '0;
      func_q        <= '0;
      alu_ctrl_q    <= '0;
      fpu_ctrl_q    <= 1'b0;
      alu_src_imm_q <= 1'b0;
      wb_sel_q      <= '0;
      trap_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      iclass_q      <= iclass_d;
      op_q          <= op_d;
      func_q        <= func_d;
      alu_ctrl_q    <= alu_ctrl_d;
      fpu_ctrl_q    <= fpu_ctrl_d;
      alu_src_imm_q <= alu_src_imm_d;
      wb_sel_q      <= wb_sel_d;
      trap_q        <= trap_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.ALUctrl       = alu_ctrl_q;
  assign bus.FPUctrl       = fpu_ctrl_q;
  assign bus.alu_src_imm   = alu_src_imm_q;
  assign bus.wb_sel        = wb_sel_q;
  assign bus.trap          = trap_q;
  assign bus.state         = state_q;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_sel_target = pc_sel_target;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.freg_write    = freg_write;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
//   Self-checking bench for mc_control. For every instruction a reference
//   trace (one expected record per clock) is built from the instruction-class
//   table, the memory wait counts and the branch flags, then played against
//   the DUT. Inputs change on the falling edge; outputs are sampled 1 time
//   unit later.
// -----------------------------------------------------------------------------
module tb_mc_control;

  localparam int TMO = 4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // Strobe vector layout:
  // {ir_write, pc_write, pc_sel_target, mem_read, mem_write, reg_write, freg_write, trap}
  localparam logic [7:0] IRW = 8'h80;
  localparam logic [7:0] PCW = 8'h40;
  localparam logic [7:0] PCS = 8'h20;
  localparam logic [7:0] MRD = 8'h10;
  localparam logic [7:0] MWR = 8'h08;
  localparam logic [7:0] RW  = 8'h04;
  localparam logic [7:0] FRW = 8'h02;
  localparam logic [7:0] TRP = 8'h01;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  strb;
    int          alu;   // -1: not checked this cycle
    int          fpu;
    int          imm;
    int          wb;
    logic        rdy;
    logic        gp;
    logic        fp;
    logic [31:0] instr;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] strobes_now();
    return {bus.ir_write, bus.pc_write, bus.pc_sel_target, bus.mem_read,
            bus.mem_write, bus.reg_write, bus.freg_write, bus.trap};
  endfunction

  // Cycle record with no expectation on the controls and random don't-care inputs.
  function automatic cyc_t mk(input logic [2:0] st, input logic [7:0] strb);
    cyc_t c;
    c.st    = st;
    c.strb  = strb;
    c.alu   = -1;
    c.fpu   = -1;
    c.imm   = -1;
    c.wb    = -1;
    c.rdy   = 1'($urandom);
    c.gp    = 1'($urandom);
    c.fp    = 1'($urandom);
    c.instr = $urandom;
    return c;
  endfunction

  task automatic add_trap();
    for (int i = 0; i < 3; i++) q.push_back(mk(S_TRAP, TRP));
  endtask

  // Reference trace for one instruction: fw FETCH waits, mw MEM waits.
  task automatic gen(input logic [5:0] op, input logic [5:0] func, input int fw,
                     input int mw, input logic gp, input logic fp, output bit trapped);
    cyc_t        c;
    bit          legal = 1'b1;
    bit          mem   = 1'b0;
    bit          load  = 1'b0;
    bit          wb    = 1'b0;
    bit          freg  = 1'b0;
    bit          taken = 1'b0;
    int          alu   = -1;
    int          fpu   = -1;
    int          imm   = -1;
    int          wbs   = -1;
    logic [31:0] r     = $urandom;
    trapped = 1'b0;
    case (op)
      6'h00: begin alu = int'(func[3:0]); imm = 0; wb = 1'b1; wbs = 0; end
      6'h01: begin fpu = int'(func[0]); wb = 1'b1; freg = 1'b1; wbs = 1; end
      6'h08: begin alu = 0; imm = 1; wb = 1'b1; wbs = 0; end
      6'h23: begin alu = 0; imm = 1; mem = 1'b1; load = 1'b1; wb = 1'b1; wbs = 2; end
      6'h2B: begin alu = 0; imm = 1; mem = 1'b1; end
      6'h04: begin alu = 12; taken = gp; end
      6'h05: begin alu = 13; taken = gp; end
      6'h06: taken = fp;
      6'h07: taken = ~fp;
      6'h02: taken = 1'b1;
      6'h03: begin taken = 1'b1; wb = 1'b1; wbs = 3; end
      default: legal = 1'b0;
    endcase

    for (int i = 0; i < fw && i < TMO; i++) begin
      c = mk(S_FETCH, MRD);
      c.rdy = 1'b0;
      q.push_back(c);
    end
    if (fw >= TMO) begin add_trap(); trapped = 1'b1; return; end
    c = mk(S_FETCH, IRW | PCW | MRD);
    c.rdy   = 1'b1;
    c.instr = {op, r[25:6], func};
    q.push_back(c);

    q.push_back(mk(S_DECODE, 8'h00));
    if (!legal) begin add_trap(); trapped = 1'b1; return; end

    c = mk(S_EXEC, taken ? (PCW | PCS) : 8'h00);
    c.alu = alu; c.fpu = fpu; c.imm = imm;
    c.gp  = gp;  c.fp  = fp;
    q.push_back(c);

    if (mem) begin
      for (int i = 0; i <= mw && i <= TMO; i++) begin
        if (i == TMO) begin add_trap(); trapped = 1'b1; return; end
        c = mk(S_MEM, load ? MRD : MWR);
        c.rdy = (i == mw);
        c.alu = alu; c.fpu = fpu; c.imm = imm;
        q.push_back(c);
      end
    end

    if (wb) begin
      c = mk(S_WB, freg ? FRW : RW);
      c.alu = alu; c.fpu = fpu; c.imm = imm; c.wb = wbs;
      q.push_back(c);
    end
  endtask

  // Plays the queued trace; must be called right at a falling edge.
  task automatic play(input bit stop_in_mem, output bit stopped);
    cyc_t c;
    stopped = 1'b0;
    while (q.size() > 0) begin
      c = q.pop_front();
      bus.instr     = c.instr;
      bus.mem_ready = c.rdy;
      bus.gp_branch = c.gp;
      bus.fp_branch = c.fp;
      #1;
      check("state", 32'(bus.state), 32'(c.st));
      check("strobes", 32'(strobes_now()), 32'(c.strb));
      if (c.alu >= 0) check("ALUctrl", 32'(bus.ALUctrl), c.alu);
      if (c.fpu >= 0) check("FPUctrl", 32'(bus.FPUctrl), c.fpu);
      if (c.imm >= 0) check("alu_src_imm", 32'(bus.alu_src_imm), c.imm);
      if (c.wb >= 0)  check("wb_sel", 32'(bus.wb_sel), c.wb);
      if (stop_in_mem && c.st == S_MEM) begin stopped = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'(S_FETCH));
    check({tag, "_strobes"}, 32'(strobes_now()), 32'h0);
    check({tag, "_ctrl"}, 32'({bus.ALUctrl, bus.FPUctrl, bus.alu_src_imm, bus.wb_sel}), 32'h0);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] func, input int fw,
                     input int mw, input logic gp, input logic fp);
    bit tr, st;
    gen(op, func, fw, mw, gp, fp, tr);
    play(1'b0, st);
  endtask

  // Assert reset mid-cycle, check at once, release on the next falling edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1 reset_check(tag);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops [11] = '{6'h00, 6'h01, 6'h08, 6'h23, 6'h2B, 6'h04,
                             6'h05, 6'h06, 6'h07, 6'h02, 6'h03};
    bit st;
    bit tr;

    reset         = 1'b1;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.gp_branch = 1'b0;
    bus.fp_branch = 1'b0;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 reset_check("por");
    @(negedge clk);
    reset = 1'b0;

    // Directed instructions.
    run(6'h00, 6'h00, 0, 0, 1'b0, 1'b0);   // R-type ADD
    run(6'h01, 6'h01, 0, 0, 1'b0, 1'b0);   // FP multiply
    run(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);   // LW, 3 MEM waits
    run(6'h05, 6'h00, 0, 0, 1'b1, 1'b0);   // BNEZ taken
    run(6'h05, 6'h00, 0, 0, 1'b0, 1'b1);   // BNEZ not taken
    run(6'h2B, 6'h00, 3, 3, 1'b0, 1'b0);   // SW, waits one short of timeout
    run(6'h03, 6'h00, 1, 0, 1'b0, 1'b0);   // JAL
    run(6'h07, 6'h00, 0, 0, 1'b0, 1'b0);   // BFPF taken on inverted flag
    run(6'h06, 6'h00, 0, 0, 1'b1, 1'b0);   // BFPT not taken

    // Randomized legal instructions.
    for (int n = 0; n < 80; n++) begin
      run(ops[$urandom_range(0, 10)], 6'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    // Reset while SW holds mem_write in MEM.
    gen(6'h2B, 6'h00, 1, 2, 1'b0, 1'b0, tr);
    play(1'b1, st);
    check("sw_reached_mem", 32'(st), 32'h1);
    pulse_reset("mid_mem");
    run(6'h00, 6'h02, 0, 0, 1'b0, 1'b0);

    // Illegal opcode after a BNEZ (leaves ALUctrl at 13 for the reset check).
    run(6'h05, 6'h00, 0, 0, 1'b1, 1'b0);
    run(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    pulse_reset("after_illegal");
    run(6'h08, 6'h00, 0, 0, 1'b0, 1'b0);

    // Timeout with mem_ready stuck low in FETCH.
    run(6'h08, 6'h00, TMO, 0, 1'b0, 1'b0);
    pulse_reset("after_fetch_tmo");

    // Timeout in MEM of a LW.
    run(6'h23, 6'h00, 0, TMO + 2, 1'b0, 1'b0);
    pulse_reset("after_mem_tmo");
    run(6'h01, 6'h00, 2, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1, "watchdog");
  end

endmodule
